// File: rtl/crdma_nd_if.sv
// Bus bundle for crdma_nd: descriptor/start handshake, per-bank address
// and read-return channels, and the merged output stream.
interface crdma_nd_if #(
  parameter int AW  = 14,
  parameter int DW  = 64,
  parameter int NCH = 2,
  parameter int CW  = $clog2(NCH),
  parameter int S0W = 7,
  parameter int S1W = 5,
  parameter int S2W = 5,
  parameter int STW = 8
);
  logic [AW-1:0]     desc_base;
  logic [S0W-1:0]    desc_size0;
  logic [S1W-1:0]    desc_size1;
  logic [S2W-1:0]    desc_size2;
  logic [STW-1:0]    desc_step0;
  logic [STW-1:0]    desc_step1;
  logic [STW-1:0]    desc_step2;
  logic [CW-1:0]     desc_bank;
  logic              desc_ilv;
  logic              start_valid;
  logic              start_ready;
  logic              busy;
  logic              done;
  logic [NCH*AW-1:0] ifm_addr;
  logic [NCH-1:0]    ifm_addr_first;
  logic [NCH-1:0]    ifm_addr_last;
  logic [NCH-1:0]    ifm_addr_valid;
  logic [NCH-1:0]    ifm_addr_ready;
  logic [NCH*DW-1:0] crdma_m_data;
  logic [NCH-1:0]    crdma_m_valid;
  logic [NCH-1:0]    crdma_m_ready;
  logic [DW-1:0]     crdma_s_data;
  logic              crdma_s_first;
  logic              crdma_s_last;
  logic              crdma_s_valid;
  logic              crdma_s_ready;
  logic              crdma_s_first_pre;

  modport master (
    input  desc_base, desc_size0, desc_size1, desc_size2,
           desc_step0, desc_step1, desc_step2, desc_bank, desc_ilv,
           start_valid, ifm_addr_ready, crdma_m_data, crdma_m_valid, crdma_s_ready,
    output start_ready, busy, done, ifm_addr, ifm_addr_first, ifm_addr_last,
           ifm_addr_valid, crdma_m_ready, crdma_s_data, crdma_s_first,
           crdma_s_last, crdma_s_valid, crdma_s_first_pre
  );

  modport slave (
    output desc_base, desc_size0, desc_size1, desc_size2,
           desc_step0, desc_step1, desc_step2, desc_bank, desc_ilv,
           start_valid, ifm_addr_ready, crdma_m_data, crdma_m_valid, crdma_s_ready,
    input  start_ready, busy, done, ifm_addr, ifm_addr_first, ifm_addr_last,
           ifm_addr_valid, crdma_m_ready, crdma_s_data, crdma_s_first,
           crdma_s_last, crdma_s_valid, crdma_s_first_pre
  );
endinterface

// File: rtl/crdma_nd.sv
// 3-D read DMA front end: walks a descriptor's address pattern over NCH banks
// and merges the bank returns back into issue order via a tag FIFO.
module crdma_nd #(
  parameter int AW  = 14,
  parameter int DW  = 64,
  parameter int NCH = 2,
  parameter int CW  = $clog2(NCH),
  parameter int S0W = 7,
  parameter int S1W = 5,
  parameter int S2W = 5,
  parameter int STW = 8,
  parameter int OFD = 8
) (
  input  logic       clk,
  input  logic       rst,
  crdma_nd_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam int FW = CW + 2;
  localparam int PW = $clog2(OFD);

  logic [1:0]     state;
  logic [S0W-1:0] i0, size0_r;
  logic [S1W-1:0] i1, size1_r;
  logic [S2W-1:0] i2, size2_r;
  logic [STW-1:0] step0_r, step1_r, step2_r;
  logic [CW-1:0]  bank_r;
  logic           ilv_r;
  logic [AW-1:0]  addr, row, plane;
  logic [AW-1:0]  row_next, plane_next;

  logic [FW-1:0]  fifo_mem [OFD];
  logic [PW:0]    wr_ptr, rd_ptr, occ;
  logic           fifo_empty, fifo_full;

  logic [CW-1:0]  sel;
  logic           is_first, is_last, issue_vld, push;
  logic [FW-1:0]  head;
  logic [CW-1:0]  head_bank;
  logic           out_free, pull_rdy, pop;
  logic [DW-1:0]  head_data;

  logic [DW-1:0]  out_data_p1;
  logic           out_first_p1, out_last_p1, vld_p1;

  assign occ        = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = occ[PW];

  assign sel        = ilv_r ? addr[CW-1:0] : bank_r;
  assign is_first   = (i0 == '0) && (i1 == '0) && (i2 == '0);
  assign is_last    = (i0 == size0_r) && (i1 == size1_r) && (i2 == size2_r);
  // No push-on-pop bypass: a full FIFO blocks issue even if it drains this cycle.
  assign issue_vld  = (state == S_RUN) && !fifo_full;
  assign push       = issue_vld && bus.ifm_addr_ready[sel];

  assign row_next   = row + AW'(step1_r);
  assign plane_next = plane + AW'(step2_r);

  assign head       = fifo_mem[rd_ptr[PW-1:0]];
  assign head_bank  = head[FW-1:2];
  assign head_data  = bus.crdma_m_data[head_bank*DW +: DW];
  assign out_free   = !vld_p1 || bus.crdma_s_ready;
  assign pull_rdy   = !fifo_empty && out_free;
  assign pop        = pull_rdy && bus.crdma_m_valid[head_bank];

  assign bus.start_ready       = (state == S_IDLE);
  assign bus.busy              = (state != S_IDLE);
  assign bus.crdma_s_first_pre = issue_vld && is_first;
  assign bus.crdma_s_data      = out_data_p1;
  assign bus.crdma_s_first     = out_first_p1;
  assign bus.crdma_s_last      = out_last_p1;
  assign bus.crdma_s_valid     = vld_p1;

  always_comb begin
    bus.ifm_addr       = '0;
    bus.ifm_addr_first = '0;
    bus.ifm_addr_last  = '0;
    bus.ifm_addr_valid = '0;
    bus.crdma_m_ready  = '0;
    for (int b = 0; b < NCH; b++) begin
      if (issue_vld && (sel == CW'(b))) begin
        bus.ifm_addr[b*AW +: AW] = addr;
        bus.ifm_addr_first[b]    = is_first;
        bus.ifm_addr_last[b]     = is_last;
        bus.ifm_addr_valid[b]    = 1'b1;
      end
      if (pull_rdy && (head_bank == CW'(b))) bus.crdma_m_ready[b] = 1'b1;
    end
  end

  // Control: FSM, walk counters, FIFO pointers, output stage valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      i0           <= '0;
      i1           <= '0;
      i2           <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.done     <= 1'b0;
      vld_p1       <= 1'b0;
      out_first_p1 <= 1'b0;
      out_last_p1  <= 1'b0;
      out_data_p1  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_valid) begin
            state <= S_RUN;
            i0    <= '0;
            i1    <= '0;
            i2    <= '0;
          end
        end
        S_RUN: begin
          if (push) begin
            if (i0 != size0_r) begin
              i0 <= i0 + 1'b1;
            end else if (i1 != size1_r) begin
              i0 <= '0;
              i1 <= i1 + 1'b1;
            end else if (i2 != size2_r) begin
              i0 <= '0;
              i1 <= '0;
              i2 <= i2 + 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (fifo_empty && !vld_p1) begin
            bus.done <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // Stage p1: registered merged output, held under backpressure
      if (pop) begin
        vld_p1       <= 1'b1;
        out_data_p1  <= head_data;
        out_first_p1 <= head[1];
        out_last_p1  <= head[0];
      end else if (bus.crdma_s_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Datapath: descriptor latch and address walk registers
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && bus.start_valid) begin
      size0_r <= bus.desc_size0;
      size1_r <= bus.desc_size1;
      size2_r <= bus.desc_size2;
      step0_r <= bus.desc_step0;
      step1_r <= bus.desc_step1;
      step2_r <= bus.desc_step2;
      bank_r  <= bus.desc_bank;
      ilv_r   <= bus.desc_ilv;
      addr    <= bus.desc_base;
      row     <= bus.desc_base;
      plane   <= bus.desc_base;
    end else if (push) begin
      if (i0 != size0_r) begin
        addr <= addr + AW'(step0_r);
      end else if (i1 != size1_r) begin
        row  <= row_next;
        addr <= row_next;
      end else if (i2 != size2_r) begin
        plane <= plane_next;
        row   <= plane_next;
        addr  <= plane_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {sel, is_first, is_last};
  end
endmodule

// File: tb/tb_crdma_nd.sv
// Directed bench for crdma_nd: table of jobs with hand-computed address
// sequences, plus sequences for backpressure, reset mid-job and start-while-busy.
module tb_crdma_nd;
  localparam int AW = 14, DW = 64, NCH = 2, CW = 1;
  localparam int S0W = 7, S1W = 5, S2W = 5, STW = 8, OFD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crdma_nd_if #(.AW(AW), .DW(DW), .NCH(NCH), .CW(CW), .S0W(S0W), .S1W(S1W),
                .S2W(S2W), .STW(STW)) bus ();
  crdma_nd #(.AW(AW), .DW(DW), .NCH(NCH), .CW(CW), .S0W(S0W), .S1W(S1W),
             .S2W(S2W), .STW(STW), .OFD(OFD)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [CW-1:0] bank;
    logic [AW-1:0] addr;
    logic          first;
    logic          last;
  } iss_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } beat_t;
  typedef struct {
    logic [AW-1:0]  base;
    logic [S0W-1:0] s0;
    logic [S1W-1:0] s1;
    logic [S2W-1:0] s2;
    logic [STW-1:0] t0;
    logic [STW-1:0] t1;
    logic [STW-1:0] t2;
    logic [CW-1:0]  bank;
    logic           ilv;
    int             n;
    int             idx;
  } job_t;

  iss_t  exp_tab[15];
  job_t  jobs[4];
  iss_t  iss_q[$];
  logic  fp_q[$];
  beat_t out_q[$];
  logic [AW-1:0] pend0[$], pend1[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  int hold_until0 = 0;
  int total = 0, bad = 0;

  function automatic logic [DW-1:0] dfun(logic [CW-1:0] b, logic [AW-1:0] a);
    return {4'hD, 3'b000, b, 42'h0, a};
  endfunction

  // Bank memories: record issues, return data in FIFO order per bank.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend0.delete();
      pend1.delete();
    end else begin
      for (int b = 0; b < NCH; b++) begin
        if (bus.ifm_addr_valid[b] && bus.ifm_addr_ready[b]) begin
          iss_q.push_back('{bank: CW'(b), addr: bus.ifm_addr[b*AW +: AW],
                            first: bus.ifm_addr_first[b], last: bus.ifm_addr_last[b]});
          fp_q.push_back(bus.crdma_s_first_pre);
          if (b == 0) pend0.push_back(bus.ifm_addr[b*AW +: AW]);
          else        pend1.push_back(bus.ifm_addr[b*AW +: AW]);
        end
      end
      if (bus.crdma_m_valid[0] && bus.crdma_m_ready[0]) void'(pend0.pop_front());
      if (bus.crdma_m_valid[1] && bus.crdma_m_ready[1]) void'(pend1.pop_front());
      if (bus.crdma_s_valid && bus.crdma_s_ready) begin
        out_q.push_back('{data: bus.crdma_s_data, first: bus.crdma_s_first,
                          last: bus.crdma_s_last});
        acc_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    #1;
    bus.crdma_m_valid[0] = (pend0.size() > 0) && (cyc >= hold_until0);
    bus.crdma_m_valid[1] = (pend1.size() > 0);
    bus.crdma_m_data[0*DW +: DW] = (pend0.size() > 0) ? dfun(1'b0, pend0[0]) : '0;
    bus.crdma_m_data[1*DW +: DW] = (pend1.size() > 0) ? dfun(1'b1, pend1[0]) : '0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_job(input job_t j);
    int k;
    @(negedge clk);
    bus.desc_base  = j.base;
    bus.desc_size0 = j.s0;
    bus.desc_size1 = j.s1;
    bus.desc_size2 = j.s2;
    bus.desc_step0 = j.t0;
    bus.desc_step1 = j.t1;
    bus.desc_step2 = j.t2;
    bus.desc_bank  = j.bank;
    bus.desc_ilv   = j.ilv;
    bus.start_valid = 1'b1;
    for (k = 0; k < 100; k++) begin
      if (bus.start_ready) break;
      @(negedge clk);
    end
    if (k == 100) chk("start_accept_timeout", 0, 1);
    @(negedge clk);
    bus.start_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int k;
    for (k = 0; k < 300; k++) begin
      if (done_cnt > prev) break;
      @(negedge clk);
    end
    chk("done_seen", 64'(done_cnt > prev), 1);
  endtask

  task automatic check_job(input job_t j, input int ib, input int ob);
    iss_t e;
    chk("issue_count", 64'(iss_q.size() - ib), 64'(j.n));
    chk("beat_count", 64'(out_q.size() - ob), 64'(j.n));
    for (int k = 0; k < j.n; k++) begin
      e = exp_tab[j.idx + k];
      if (ib + k < iss_q.size()) begin
        chk($sformatf("iss_bank[%0d]", k),  64'(iss_q[ib+k].bank),  64'(e.bank));
        chk($sformatf("iss_addr[%0d]", k),  64'(iss_q[ib+k].addr),  64'(e.addr));
        chk($sformatf("iss_first[%0d]", k), 64'(iss_q[ib+k].first), 64'(e.first));
        chk($sformatf("iss_last[%0d]", k),  64'(iss_q[ib+k].last),  64'(e.last));
        chk($sformatf("first_pre[%0d]", k), 64'(fp_q[ib+k]),        64'(e.first));
      end
      if (ob + k < out_q.size()) begin
        chk($sformatf("out_data[%0d]", k),  out_q[ob+k].data,        dfun(e.bank, e.addr));
        chk($sformatf("out_first[%0d]", k), 64'(out_q[ob+k].first),  64'(e.first));
        chk($sformatf("out_last[%0d]", k),  64'(out_q[ob+k].last),   64'(e.last));
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_start_ready"}, 64'(bus.start_ready), 1);
    chk({tag, "_busy"},        64'(bus.busy), 0);
    chk({tag, "_done"},        64'(bus.done), 0);
    chk({tag, "_addr_valid"},  64'(bus.ifm_addr_valid), 0);
    chk({tag, "_addr"},        64'(bus.ifm_addr), 0);
    chk({tag, "_m_ready"},     64'(bus.crdma_m_ready), 0);
    chk({tag, "_s_valid"},     64'(bus.crdma_s_valid), 0);
    chk({tag, "_s_data"},      bus.crdma_s_data, 0);
    chk({tag, "_first_pre"},   64'(bus.crdma_s_first_pre), 0);
  endtask

  initial begin
    int ib, ob, dc, k;
    logic [DW-1:0] held;
    job_t bp;

    // 3x2 walk on bank 1
    exp_tab[0]  = '{1'b1, 14'h100, 1'b1, 1'b0};
    exp_tab[1]  = '{1'b1, 14'h101, 1'b0, 1'b0};
    exp_tab[2]  = '{1'b1, 14'h102, 1'b0, 1'b0};
    exp_tab[3]  = '{1'b1, 14'h110, 1'b0, 1'b0};
    exp_tab[4]  = '{1'b1, 14'h111, 1'b0, 1'b0};
    exp_tab[5]  = '{1'b1, 14'h112, 1'b0, 1'b1};
    // interleave across the 2^14 wrap
    exp_tab[6]  = '{1'b0, 14'h3FFE, 1'b1, 1'b0};
    exp_tab[7]  = '{1'b1, 14'h3FFF, 1'b0, 1'b0};
    exp_tab[8]  = '{1'b0, 14'h0000, 1'b0, 1'b0};
    exp_tab[9]  = '{1'b1, 14'h0001, 1'b0, 1'b1};
    // single element
    exp_tab[10] = '{1'b0, 14'h02A, 1'b1, 1'b1};
    // dim2 walk with plane wrap: 0x3FF0 + 0x20 -> 0x0010
    exp_tab[11] = '{1'b1, 14'h3FF0, 1'b1, 1'b0};
    exp_tab[12] = '{1'b1, 14'h3FF4, 1'b0, 1'b0};
    exp_tab[13] = '{1'b1, 14'h0010, 1'b0, 1'b0};
    exp_tab[14] = '{1'b1, 14'h0014, 1'b0, 1'b1};

    jobs[0] = '{base: 14'h100,  s0: 2, s1: 1, s2: 0, t0: 1, t1: 8'h10, t2: 0,
                bank: 1'b1, ilv: 1'b0, n: 6, idx: 0};
    jobs[1] = '{base: 14'h3FFE, s0: 3, s1: 0, s2: 0, t0: 1, t1: 0, t2: 0,
                bank: 1'b0, ilv: 1'b1, n: 4, idx: 6};
    jobs[2] = '{base: 14'h02A,  s0: 0, s1: 0, s2: 0, t0: 0, t1: 0, t2: 0,
                bank: 1'b0, ilv: 1'b0, n: 1, idx: 10};
    jobs[3] = '{base: 14'h3FF0, s0: 1, s1: 0, s2: 1, t0: 4, t1: 0, t2: 8'h20,
                bank: 1'b1, ilv: 1'b0, n: 4, idx: 11};

    rst = 1'b1;
    bus.desc_base = '0; bus.desc_size0 = '0; bus.desc_size1 = '0; bus.desc_size2 = '0;
    bus.desc_step0 = '0; bus.desc_step1 = '0; bus.desc_step2 = '0;
    bus.desc_bank = '0; bus.desc_ilv = 1'b0; bus.start_valid = 1'b0;
    bus.ifm_addr_ready = '1; bus.crdma_s_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      ib = iss_q.size(); ob = out_q.size(); dc = done_cnt;
      if (t == 1) hold_until0 = cyc + 6;
      start_job(jobs[t]);
      wait_done(dc);
      repeat (3) @(negedge clk);
      check_job(jobs[t], ib, ob);
      chk($sformatf("done_pulses_job%0d", t), 64'(done_cnt - dc), 1);
      chk($sformatf("idle_after_job%0d", t), 64'(bus.busy), 0);
      if (t == 2) chk("single_done_latency", 64'(done_cyc - acc_cyc), 2);
    end

    // Backpressure: 12 elements, bank 0 stalled and output blocked
    bp = '{base: 14'h200, s0: 11, s1: 0, s2: 0, t0: 1, t1: 0, t2: 0,
           bank: 1'b0, ilv: 1'b0, n: 12, idx: 0};
    ib = iss_q.size(); ob = out_q.size(); dc = done_cnt;
    bus.crdma_s_ready = 1'b0;
    hold_until0 = cyc + 40;
    start_job(bp);
    repeat (20) @(negedge clk);
    chk("bp_issued_full", 64'(iss_q.size() - ib), OFD);
    chk("bp_valid_held", 64'(bus.ifm_addr_valid), 0);
    repeat (30) @(negedge clk);
    chk("bp_s_valid", 64'(bus.crdma_s_valid), 1);
    chk("bp_s_first", 64'(bus.crdma_s_first), 1);
    chk("bp_issued_after_pop", 64'(iss_q.size() - ib), OFD + 1);
    held = dfun(1'b0, 14'h200);
    for (k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold_data[%0d]", k), bus.crdma_s_data, held);
      @(negedge clk);
    end
    bus.crdma_s_ready = 1'b1;
    wait_done(dc);
    repeat (2) @(negedge clk);
    chk("bp_beats", 64'(out_q.size() - ob), 12);
    chk("bp_issued_total", 64'(iss_q.size() - ib), 12);
    for (k = 0; k < 12; k++) begin
      if (ob + k < out_q.size()) begin
        chk($sformatf("bp_data[%0d]", k),  out_q[ob+k].data, dfun(1'b0, AW'(14'h200 + k)));
        chk($sformatf("bp_first[%0d]", k), 64'(out_q[ob+k].first), 64'(k == 0));
        chk($sformatf("bp_last[%0d]", k),  64'(out_q[ob+k].last),  64'(k == 11));
      end
    end

    // Reset after 3 of 6 addresses
    ib = iss_q.size();
    start_job(jobs[0]);
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (iss_q.size() - ib >= 3) break;
    end
    rst = 1'b1;
    dc = done_cnt;
    @(negedge clk);
    check_idle("midrst");
    chk("midrst_issued", 64'(iss_q.size() - ib), 3);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - dc), 0);
    ib = iss_q.size(); ob = out_q.size(); dc = done_cnt;
    start_job(jobs[0]);
    wait_done(dc);
    repeat (3) @(negedge clk);
    check_job(jobs[0], ib, ob);

    // Start pulse while busy is ignored
    ib = iss_q.size(); ob = out_q.size(); dc = done_cnt;
    start_job(jobs[0]);
    @(negedge clk);
    chk("busy_in_run", 64'(bus.busy), 1);
    chk("start_ready_in_run", 64'(bus.start_ready), 0);
    bus.desc_base = 14'h300;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    wait_done(dc);
    repeat (4) @(negedge clk);
    check_job(jobs[0], ib, ob);
    chk("ignored_start_idle", 64'(bus.busy), 0);
    ib = iss_q.size(); ob = out_q.size(); dc = done_cnt;
    start_job(jobs[2]);
    wait_done(dc);
    repeat (3) @(negedge clk);
    check_job(jobs[2], ib, ob);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/crdma_nd.md
Name: crdma_nd

Overview:
- Parametrised successor of the 2-D read DMA front end (conv datapath).
- Accepts one descriptor per job and walks a 3-D address pattern.
- Steers addresses to NCH memory banks, either a fixed bank or address-interleaved.
- Merges the bank read returns back into issue order through a tag FIFO, with a backpressured registered output.

Parameters:
- AW, 14, address width
- DW, 64, return data width per bank
- NCH, 2, number of banks (power of 2, ≥2)
- CW, $clog2(NCH), bank index width
- S0W, 7, dim0 size field width
- S1W, 5, dim1 size field width
- S2W, 5, dim2 size field width
- STW, 8, step field width (unsigned)
- OFD, 8, order FIFO depth (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- desc_base  in  AW  start address
- desc_size0 / desc_size1 / desc_size2  in  S0W / S1W / S2W  element count minus 1 per dim
- desc_step0 / desc_step1 / desc_step2  in  STW each  address increment per dim
- desc_bank  in  CW  target bank in fixed mode
- desc_ilv  in  1  1 = interleave mode, bank = addr[CW-1:0]
- start_valid  in  1  descriptor valid
- start_ready  out  1  descriptor accepted
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- ifm_addr  out  NCH*AW  per-bank address, bank b at [b*AW +: AW]
- ifm_addr_first / ifm_addr_last / ifm_addr_valid  out  NCH each  per-bank flags
- ifm_addr_ready  in  NCH  per-bank ready
- crdma_m_data  in  NCH*DW  per-bank read data
- crdma_m_valid  in  NCH  per-bank data valid
- crdma_m_ready  out  NCH  per-bank data ready
- crdma_s_data  out  DW  merged data
- crdma_s_first / crdma_s_last / crdma_s_valid  out  1 each  merged stream flags
- crdma_s_ready  in  1  downstream ready
- crdma_s_first_pre  out  1  high while the job's first address is presented

Behaviour:
- Reset values:
  - All outputs 0, except start_ready = 1.
  - FSM = IDLE, counters 0, FIFO empty.
  - Reset mid-job aborts it. No done pulse; in-flight bank data is not tracked.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start_ready = 1. On start_valid, latch the descriptor, set i0 = i1 = i2 = 0, addr = row = plane = base, go to RUN. start_valid is ignored outside IDLE.
  - RUN: present addr on the selected bank only; other banks' valid = 0.
  - Address handshake = valid & ready of the selected bank, and requires the order FIFO not full. When the FIFO is full, valid is held 0; there is no same-cycle push-on-pop bypass.
  - On handshake, push {bank, first, last} to the FIFO, then advance:
    - i0 < size0: i0++, addr += step0.
    - else if i1 < size1: i0 = 0, i1++, row += step1, addr = row + step1.
    - else if i2 < size2: i0 = i1 = 0, i2++, plane += step2, row = addr = plane + step2.
    - else: go to DRAIN.
  - All address sums are modulo 2^AW; wrap is silent.
  - first = (i0, i1, i2 all 0). last = (i0 == size0 and i1 == size1 and i2 == size2).
  - DRAIN: when FIFO empty and crdma_s_valid == 0, pulse done and go to IDLE. done and start_ready rise in the same cycle as that transition completes.
- busy = (state != IDLE).
- Return merge:
  - The FIFO head bank h selects the source.
  - crdma_m_ready[h] = FIFO non-empty & (!crdma_s_valid | crdma_s_ready). All other bank readies are 0.
  - On that handshake, pop the FIFO and register data, first and last into the output stage.
  - Latency: 1 cycle from bank handshake to crdma_s_valid.
  - Full throughput of 1 beat/cycle under continuous ready.
  - Bank-side ordering across banks is enforced purely by the FIFO.
  - The output stage holds its data while crdma_s_valid & !crdma_s_ready.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- Single-element job (all sizes 0): one address with first = last = 1, straight to DRAIN.

Test Plan:
1. Basic 3x2 walk: base = 0x100, size0 = 2, step0 = 1, size1 = 1, step1 = 0x10, size2 = 0, fixed bank 1, all ready = 1.
   -> Bank 1 addresses 0x100, 0x101, 0x102, 0x110, 0x111, 0x112.
   -> first only on 0x100, last only on 0x112.
   -> 6 output beats in order, crdma_s_first on beat 0, crdma_s_last on beat 5, done one pulse.
2. Interleave: base = 0x3FFE, AW = 14, size0 = 3, step0 = 1, desc_ilv = 1.
   -> Addresses 0x3FFE (bank 0), 0x3FFF (bank 1), 0x0000 (bank 0), 0x0001 (bank 1).
   -> Bank 1 returns first with bank 0 delayed 3 cycles: output is still in issue order.
3. Backpressure: crdma_s_ready held 0 after first beat, job of 12 elements.
   -> Exactly OFD = 8 addresses issued, then valid stays 0.
   -> crdma_s_data is stable throughout.
   -> Releasing ready completes all 12 beats with none lost or duplicated.
4. Single element: all sizes 0, base = 0x2A.
   -> One address 0x2A with first = last = 1.
   -> crdma_s_first_pre high that cycle.
   -> done 1 cycle after the output beat is accepted.
5. Reset mid-job: assert rst after 3 of 6 addresses.
   -> All outputs 0, start_ready = 1 on the next edge, no done pulse.
   -> A new descriptor then runs cleanly.
6. Start while busy: pulse start_valid during RUN.
   -> Ignored, start_ready = 0.
   -> The second job begins only after done.
